alu_exec_stage: RTL and testbench

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

---
 rtl/alu_exec_stage.sv | 147 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage with a one-entry skid buffer behind the output register.
// 1-cycle latency when the output register is free or draining; in_ready is registered and drops only when the skid entry is occupied.
module alu_exec_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_ctrl,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [4:0]      out_rd
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_ANDX = 3'b010;
  localparam logic [2:0] OP_ORSR = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SRA  = 3'b111;

  logic [XLEN-1:0] alu_res;
  logic            alu_zero;
  logic [4:0]      shamt;

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic [4:0]      out_rd_q, out_rd_d;

  logic            skid_full_q, skid_full_d;
  logic [XLEN-1:0] skid_res_q, skid_res_d;
  logic            skid_zero_q, skid_zero_d;
  logic [4:0]      skid_rd_q, skid_rd_d;

  logic            in_ready_q, in_ready_d;

  logic            accept;
  logic            out_free;

  assign shamt = src_b[4:0];

  always_comb begin
    alu_res = '0;
    unique case (alu_ctrl)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_ANDX: alu_res = (funct3 == 3'b111) ? (src_a & src_b) : (src_a ^ src_b);
      OP_ORSR: alu_res = (funct3 == 3'b110) ? (src_a | src_b) : (src_a >> shamt);
      OP_SLL:  alu_res = src_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  assign accept   = in_valid && in_ready_q && !flush;
  // Output register may be loaded when it is empty or handing off this edge.
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_rd_d    = out_rd_q;
    skid_full_d = skid_full_q;
    skid_res_d  = skid_res_q;
    skid_zero_d = skid_zero_q;
    skid_rd_d   = skid_rd_q;

    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (out_free) begin
      if (skid_full_q) begin
        out_valid_d = 1'b1;
        result_d    = skid_res_q;
        zero_d      = skid_zero_q;
        out_rd_d    = skid_rd_q;
        skid_full_d = accept;
        if (accept) begin
          skid_res_d  = alu_res;
          skid_zero_d = alu_zero;
          skid_rd_d   = rd;
        end
      end else if (accept) begin
        out_valid_d = 1'b1;
        result_d    = alu_res;
        zero_d      = alu_zero;
        out_rd_d    = rd;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_full_d = 1'b1;
      skid_res_d  = alu_res;
      skid_zero_d = alu_zero;
      skid_rd_d   = rd;
    end

    in_ready_d = !skid_full_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_rd_q    <= '0;
      skid_full_q <= 1'b0;
      skid_res_q  <= '0;
      skid_zero_q <= 1'b0;
      skid_rd_q   <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_rd_q    <= out_rd_d;
      skid_full_q <= skid_full_d;
      skid_res_q  <= skid_res_d;
      skid_zero_q <= skid_zero_d;
      skid_rd_q   <= skid_rd_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign out_rd    = out_rd_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: decode, latency, skid backpressure, flush and reset.
module tb_alu_exec_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_ctrl;
  logic [2:0]  funct3;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic [4:0]  out_rd;

  int tests = 0;
  int fails = 0;

  alu_exec_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .funct3(funct3), .src_a(src_a), .src_b(src_b),
    .rd(rd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .out_rd(out_rd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r);
    in_valid = 1'b1;
    alu_ctrl = c;
    funct3   = f;
    src_a    = a;
    src_b    = b;
    rd       = r;
  endtask

  task automatic out_chk(input string tag, input logic [31:0] res, input logic z, input logic [4:0] r);
    chk({tag, "_vld"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_res"}, result, res);
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, z});
    chk({tag, "_rd"}, {27'b0, out_rd}, {27'b0, r});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_ctrl = 3'd0; funct3 = 3'd0;
    src_a = 32'd0; src_b = 32'd0; rd = 5'd0; flush = 1'b0; out_ready = 1'b1;

    // Reset state
    step(); step();
    chk("rst_vld", {31'b0, out_valid}, 32'd0);
    chk("rst_res", result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_rd", {27'b0, out_rd}, 32'd0);
    chk("rst_rdy", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_rdy", {31'b0, in_ready}, 32'd1);
    chk("post_rst_vld", {31'b0, out_valid}, 32'd0);

    // Streaming decode checks, one op per cycle with out_ready=1
    drive(3'b000, 3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3); step();
    out_chk("add_ovf", 32'h8000_0000, 1'b0, 5'd3);
    drive(3'b001, 3'b000, 32'd5, 32'd5, 5'd7); step();
    out_chk("sub_zero", 32'd0, 1'b1, 5'd7);
    drive(3'b111, 3'b000, 32'h8000_0000, 32'h0000_0024, 5'd1); step();
    out_chk("sra", 32'hF800_0000, 1'b0, 5'd1);
    drive(3'b010, 3'b111, 32'h0000_F0F0, 32'h0000_FF00, 5'd2); step();
    out_chk("and", 32'h0000_F000, 1'b0, 5'd2);
    drive(3'b010, 3'b100, 32'h0000_F0F0, 32'h0000_FF00, 5'd4); step();
    out_chk("xor", 32'h0000_0FF0, 1'b0, 5'd4);
    drive(3'b011, 3'b110, 32'h0000_F0F0, 32'h0000_FF00, 5'd5); step();
    out_chk("or", 32'h0000_FFF0, 1'b0, 5'd5);
    drive(3'b011, 3'b101, 32'h8000_F0F0, 32'hFFFF_FFE4, 5'd6); step();
    out_chk("srl", 32'h0800_0F0F, 1'b0, 5'd6);
    drive(3'b100, 3'b000, 32'h0000_0003, 32'h0000_003F, 5'd8); step();
    out_chk("sll", 32'h8000_0000, 1'b0, 5'd8);
    drive(3'b101, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd9); step();
    out_chk("slt", 32'd1, 1'b0, 5'd9);
    drive(3'b110, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 5'd10); step();
    out_chk("sltu", 32'd0, 1'b1, 5'd10);
    in_valid = 1'b0; step();
    chk("drain_vld", {31'b0, out_valid}, 32'd0);

    // Backpressure: A held, B in skid, C refused until drain
    out_ready = 1'b0;
    drive(3'b000, 3'b000, 32'd1, 32'd1, 5'd11); step();
    out_chk("bp_A", 32'd2, 1'b0, 5'd11);
    chk("bp_rdy_A", {31'b0, in_ready}, 32'd1);
    drive(3'b000, 3'b000, 32'd2, 32'd2, 5'd12); step();
    out_chk("bp_A_hold", 32'd2, 1'b0, 5'd11);
    chk("bp_rdy_B", {31'b0, in_ready}, 32'd0);
    drive(3'b000, 3'b000, 32'd3, 32'd3, 5'd13); step();
    out_chk("bp_A_hold2", 32'd2, 1'b0, 5'd11);
    chk("bp_rdy_C", {31'b0, in_ready}, 32'd0);
    out_ready = 1'b1; step();
    out_chk("bp_B", 32'd4, 1'b0, 5'd12);
    chk("bp_rdy_back", {31'b0, in_ready}, 32'd1);
    step();
    out_chk("bp_C", 32'd6, 1'b0, 5'd13);
    in_valid = 1'b0; step();
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    // Flush with both entries full and a simultaneous input
    out_ready = 1'b0;
    drive(3'b000, 3'b000, 32'h10, 32'h0, 5'd14); step();
    drive(3'b000, 3'b000, 32'h20, 32'h0, 5'd15); step();
    chk("fl_full_rdy", {31'b0, in_ready}, 32'd0);
    drive(3'b000, 3'b000, 32'h30, 32'h0, 5'd16);
    flush = 1'b1; step();
    chk("fl_vld", {31'b0, out_valid}, 32'd0);
    chk("fl_rdy", {31'b0, in_ready}, 32'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk("fl_no_ghost", {31'b0, out_valid}, 32'd0);
    drive(3'b000, 3'b000, 32'h55, 32'h0, 5'd17); step();
    out_chk("fl_after", 32'h55, 1'b0, 5'd17);
    in_valid = 1'b0; step();
    chk("fl_after_empty", {31'b0, out_valid}, 32'd0);

    // Reset while two ops are held
    out_ready = 1'b0;
    drive(3'b000, 3'b000, 32'h40, 32'h1, 5'd18); step();
    drive(3'b000, 3'b000, 32'h50, 32'h1, 5'd19); step();
    chk("mr_full_rdy", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0; rst_n = 1'b0; step();
    chk("mr_vld", {31'b0, out_valid}, 32'd0);
    chk("mr_res", result, 32'd0);
    chk("mr_rdy", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b1; out_ready = 1'b1; step();
    chk("mr_rdy_back", {31'b0, in_ready}, 32'd1);
    chk("mr_no_ghost", {31'b0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
